// File: rtl/sonar_if.sv
// sonar_if: bundles the control, echo/trigger pin and result signals of the
// sonar_scheduler.
//   en, mask, echo                            : controller inputs
//   trig, busy                                : trigger pins and activity flag
//   dist_valid, dist_id, dist_cm, dist_timeout: tagged result stream
//   near                                      : per-sensor proximity flags
// master = the surrounding logic / pins, slave = the scheduler.
interface sonar_if #(
    parameter int N_SENSORS = 4,
    parameter int DIST_W    = 18
);
    localparam int IW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

    logic                 en;
    logic [N_SENSORS-1:0] mask;
    logic [N_SENSORS-1:0] echo;
    logic [N_SENSORS-1:0] trig;
    logic                 busy;
    logic                 dist_valid;
    logic [IW-1:0]        dist_id;
    logic [DIST_W-1:0]    dist_cm;
    logic                 dist_timeout;
    logic [N_SENSORS-1:0] near;

    modport master (
        output en, mask, echo,
        input  trig, busy, dist_valid, dist_id, dist_cm, dist_timeout, near
    );

    modport slave (
        input  en, mask, echo,
        output trig, busy, dist_valid, dist_id, dist_cm, dist_timeout, near
    );
endinterface

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin controller sharing one echo-timing datapath
// among N_SENSORS HC-SR04 style rangers. Each ping fires one trigger, times
// the echo pulse, converts it to cm by counting DIV_CYCLES per cm, reports a
// tagged result and then waits out a ring-down gap.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : sonar_if.slave (en/mask/echo in; trig/busy/result/near out)
module sonar_scheduler #(
    parameter int N_SENSORS      = 4,
    parameter int TRIG_CYCLES    = 500,
    parameter int DIV_CYCLES     = 2900,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int GAP_CYCLES     = 3000000,
    parameter int DIST_W         = 18,
    parameter int NEAR_CM        = 20
) (
    input  logic     clk,
    input  logic     rst_n,
    sonar_if.slave   bus
);
    localparam int IW   = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
    localparam int CMAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW   = $clog2(DIV_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_TRIG, S_WAIT_RISE, S_MEASURE, S_REPORT, S_GAP
    } state_t;

    state_t state, state_nxt;

    logic [N_SENSORS-1:0] echo_s1, echo_s2, echo_d;
    logic [IW-1:0]        ptr, sel_id;
    logic [CW-1:0]        cnt;
    logic [TW-1:0]        tmo;
    logic [SW-1:0]        sub;
    logic [DIST_W-1:0]    cm;

    logic                 dist_valid_q, dist_timeout_q;
    logic [IW-1:0]        dist_id_q;
    logic [DIST_W-1:0]    dist_cm_q;
    logic [N_SENSORS-1:0] near_q, trig_w;
    logic                 busy_w;

    logic echo_cur, echo_rise, echo_fall, tmo_hit, trig_done, gap_done, any_mask;

    // Only the selected sensor's synced echo is ever looked at.
    assign echo_cur  = echo_s2[ptr];
    assign echo_rise = echo_cur & ~echo_d[ptr];
    assign echo_fall = ~echo_cur & echo_d[ptr];
    assign any_mask  = |bus.mask;
    assign trig_done = (cnt == CW'(TRIG_CYCLES - 1));
    assign gap_done  = (cnt == CW'(GAP_CYCLES - 1));
    assign tmo_hit   = ((state == S_WAIT_RISE) || (state == S_MEASURE)) &&
                       (tmo == TW'(TIMEOUT_CYCLES - 1));

    // Next sensor after ptr, wrapping. The low pass picks the smallest index
    // at or below ptr, the high pass overrides it with the smallest index
    // above ptr, so ptr itself is only chosen when nothing else is enabled.
    always_comb begin
        sel_id = ptr;
        for (int i = N_SENSORS - 1; i >= 0; i--)
            if (bus.mask[i] && (i <= int'(ptr))) sel_id = IW'(i);
        for (int i = N_SENSORS - 1; i >= 0; i--)
            if (bus.mask[i] && (i > int'(ptr))) sel_id = IW'(i);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; timeout wins over a same-cycle echo edge.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (bus.en && any_mask) state_nxt = S_SELECT;
            S_SELECT:    state_nxt = any_mask ? S_TRIG : S_IDLE;
            S_TRIG:      if (trig_done) state_nxt = S_WAIT_RISE;
            S_WAIT_RISE: if (tmo_hit) state_nxt = S_REPORT;
                         else if (echo_rise) state_nxt = S_MEASURE;
            S_MEASURE:   if (tmo_hit || echo_fall) state_nxt = S_REPORT;
            S_REPORT:    state_nxt = S_GAP;
            S_GAP:       if (gap_done) state_nxt = bus.en ? S_SELECT : S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        trig_w = '0;
        if (state == S_TRIG) trig_w[ptr] = 1'b1;
        busy_w = (state != S_IDLE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            echo_s1        <= '0;
            echo_s2        <= '0;
            echo_d         <= '0;
            ptr            <= IW'(N_SENSORS - 1);
            cnt            <= '0;
            tmo            <= '0;
            sub            <= '0;
            cm             <= '0;
            dist_valid_q   <= 1'b0;
            dist_timeout_q <= 1'b0;
            dist_id_q      <= '0;
            dist_cm_q      <= '0;
            near_q         <= '0;
        end else begin
            echo_s1 <= bus.echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;

            // Phase counter restarts on every state change (TRIG and GAP).
            cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;

            if (state == S_SELECT && any_mask) ptr <= sel_id;

            if (state == S_TRIG && trig_done)
                tmo <= '0;
            else if (state == S_WAIT_RISE || state == S_MEASURE)
                tmo <= tmo + 1'b1;

            if (state == S_WAIT_RISE) begin
                sub <= '0;
                cm  <= '0;
            end else if (state == S_MEASURE && echo_cur) begin
                if (sub == SW'(DIV_CYCLES - 1)) begin
                    sub <= '0;
                    if (cm != '1) cm <= cm + 1'b1;
                end else begin
                    sub <= sub + 1'b1;
                end
            end

            // Result is latched on entry to REPORT so it is valid during it.
            dist_valid_q <= (state_nxt == S_REPORT);
            if (state_nxt == S_REPORT) begin
                dist_id_q      <= ptr;
                dist_timeout_q <= tmo_hit;
                dist_cm_q      <= tmo_hit ? '1 : cm;
                near_q[ptr]    <= ~tmo_hit & (cm < DIST_W'(NEAR_CM));
            end
        end
    end

    assign bus.trig         = trig_w;
    assign bus.busy         = busy_w;
    assign bus.dist_valid   = dist_valid_q;
    assign bus.dist_id      = dist_id_q;
    assign bus.dist_cm      = dist_cm_q;
    assign bus.dist_timeout = dist_timeout_q;
    assign bus.near         = near_q;
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed + randomized bench for sonar_scheduler with
// small timing parameters. Echo responses are generated per ping from a
// pulse description; expected results come from the ranging rules directly.
module tb_sonar_scheduler;
    localparam int N      = 4;
    localparam int TRIG_C = 4;
    localparam int DIV_C  = 10;
    localparam int TMO_C  = 200;
    localparam int GAP_C  = 20;
    localparam int NEAR_C = 3;
    localparam int DW     = 18;

    // echo response modes
    localparam int M_NORMAL = 0;  // low dly cycles, then high wid cycles
    localparam int M_NONE   = 1;  // never answers
    localparam int M_STUCK  = 2;  // high from during trig for wid cycles
    localparam int M_STALE  = 3;  // high at trig fall, low dly, high wid

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sonar_if #(.N_SENSORS(N), .DIST_W(DW)) bus();

    sonar_scheduler #(
        .N_SENSORS(N), .TRIG_CYCLES(TRIG_C), .DIV_CYCLES(DIV_C),
        .TIMEOUT_CYCLES(TMO_C), .GAP_CYCLES(GAP_C), .DIST_W(DW), .NEAR_CM(NEAR_C)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int rr_ptr = N - 1;
    int gap_cnt = -1;
    logic [N-1:0] near_m = '0;
    logic [DW-1:0] last_cm = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int next_rr(input int p, input logic [N-1:0] m);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            sh = m >> ((p + k) % N);
            if (sh[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit pat(input int mode, input int dly, input int wid, input int t);
        case (mode)
            M_NORMAL: return (t >= dly) && (t < dly + wid);
            M_STUCK:  return t < wid;
            M_STALE:  return (t < 1) || ((t >= 1 + dly) && (t < 1 + dly + wid));
            default:  return 1'b0;
        endcase
    endfunction

    // One full ping: find the trigger, answer it, check the reported result.
    task automatic ping(input int mode, input int dly, input int wid, input int drop_en_at);
        int c, s, tw, t, exp_s, exp_cm;
        bit exp_to, seen;
        logic [N-1:0] sh;
        exp_s = next_rr(rr_ptr, bus.mask);
        c = (gap_cnt >= 0) ? gap_cnt : 0;
        while (bus.trig == '0 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("trig_seen", bus.trig != '0, 1);
        if (gap_cnt >= 0) chk("gap_to_trig", c, GAP_C + 2);
        chk("trig_onehot", $onehot(bus.trig), 1);
        s = 0;
        for (int i = 0; i < N; i++) begin
            sh = bus.trig >> i;
            if (sh[0]) s = i;
        end
        chk("trig_id", s, exp_s);
        rr_ptr = exp_s;
        if (mode == M_STUCK || mode == M_STALE) bus.echo = N'(1) << s;
        tw = 0;
        sh = bus.trig >> s;
        while (sh[0] && tw < 100) begin
            tw++;
            @(negedge clk);
            sh = bus.trig >> s;
        end
        chk("trig_width", tw, TRIG_C);
        // t = 0 is the first cycle with the trigger low
        seen = 1'b0;
        for (t = 0; t < TMO_C + 50; t++) begin
            if (t == drop_en_at) bus.en = 1'b0;
            bus.echo = pat(mode, dly, wid, t) ? (N'(1) << s) : '0;
            if (bus.dist_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.echo = '0;
        chk("valid_seen", seen, 1);
        exp_to = (mode == M_NONE) || (mode == M_STUCK);
        exp_cm = exp_to ? (2 ** DW - 1) : (wid - 1) / DIV_C;
        if (exp_to) chk("timeout_latency", t, TMO_C);
        near_m = near_m & ~(N'(1) << s);
        if (!exp_to && exp_cm < NEAR_C) near_m = near_m | (N'(1) << s);
        chk("dist_id", bus.dist_id, exp_s);
        chk("dist_timeout", bus.dist_timeout, exp_to);
        chk("dist_cm", bus.dist_cm, exp_cm);
        chk("near", bus.near, near_m);
        last_cm = DW'(exp_cm);
        @(negedge clk);
        chk("valid_one_cycle", bus.dist_valid, 0);
        gap_cnt = 1;
    endtask

    initial begin
        int any_trig, any_valid, busy_fall;
        bus.en = 1'b0;
        bus.mask = '0;
        bus.echo = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_trig", bus.trig, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.dist_valid, 0);
        chk("rst_timeout", bus.dist_timeout, 0);
        chk("rst_cm", bus.dist_cm, 0);
        chk("rst_id", bus.dist_id, 0);
        chk("rst_near", bus.near, 0);
        rst_n = 1'b1;

        // first ping: sensor 0, 35-cycle echo -> 3 cm, not near
        bus.en = 1'b1;
        bus.mask = 4'b1111;
        ping(M_NORMAL, 5, 35, -1);

        // round robin over 1 and 3
        bus.mask = 4'b1010;
        for (int i = 0; i < 4; i++)
            ping(M_NORMAL, $urandom_range(1, 20), $urandom_range(1, 100), -1);

        // sensor 2: no echo, then echo stuck high
        bus.mask = 4'b0100;
        ping(M_NONE, 0, 0, -1);
        ping(M_STUCK, 0, 250, -1);

        // stale echo on sensor 0: fresh 25-cycle pulse -> 2 cm, near
        bus.mask = 4'b0001;
        ping(M_STALE, 10, 25, -1);

        // randomized masks and responses
        for (int i = 0; i < 8; i++) begin
            bus.mask = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 4) == 0) ping(M_NONE, 0, 0, -1);
            else ping(M_NORMAL, $urandom_range(1, 30), $urandom_range(1, 120), -1);
        end

        // en dropped during MEASURE: result and gap complete, then idle
        bus.mask = 4'b1111;
        ping(M_NORMAL, 5, 60, 20);
        any_trig = 0;
        busy_fall = -1;
        for (int c = 1; c <= 60; c++) begin
            if (bus.trig != '0) any_trig++;
            if (!bus.busy && busy_fall < 0) busy_fall = c;
            @(negedge clk);
        end
        chk("en_off_no_trig", any_trig, 0);
        chk("en_off_busy_fall", busy_fall, GAP_C + 1);
        chk("en_off_idle", bus.busy, 0);

        // mask cleared during GAP: back to IDLE, result held
        gap_cnt = -1;
        bus.en = 1'b1;
        ping(M_NORMAL, 3, 15, -1);
        bus.mask = '0;
        any_trig = 0;
        any_valid = 0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.trig != '0) any_trig++;
            if (bus.dist_valid) any_valid++;
            @(negedge clk);
        end
        chk("mask0_no_trig", any_trig, 0);
        chk("mask0_no_valid", any_valid, 0);
        chk("mask0_idle", bus.busy, 0);
        chk("mask0_cm_held", bus.dist_cm, last_cm);

        // reset during TRIG
        gap_cnt = -1;
        bus.mask = 4'b1111;
        any_trig = 0;
        for (int c = 0; c < 50 && bus.trig == '0; c++) @(negedge clk);
        chk("rst_trig_seen", bus.trig != '0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_trig", bus.trig, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_near", bus.near, 0);
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        any_valid = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.dist_valid) any_valid++;
            if (bus.trig != '0) any_trig++;
            @(negedge clk);
        end
        chk("midrst_no_valid", any_valid, 0);
        chk("midrst_no_trig", any_trig, 0);
        rr_ptr = N - 1;
        near_m = '0;

        // after reset the first sensor served is 0 again
        bus.en = 1'b1;
        ping(M_NORMAL, 4, 12, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sonar_scheduler.md
Name: sonar_scheduler

Overview:
- Round-robin controller that shares one echo-timing datapath among N ultrasonic rangers (HC-SR04 style).
- Per ping: fires one sensor's trigger, times its echo pulse, converts the width to centimetres by repeated counting (no divider), then enforces a ring-down gap before the next sensor.
- Sits between the GPIO echo/trigger pins and the display/proximity logic.
- Results stream out as tagged valid pulses.

Parameters:
- N_SENSORS, 4, number of rangers served (2..8).
- TRIG_CYCLES, 500, trigger pulse width in clk cycles (10 us at 50 MHz).
- DIV_CYCLES, 2900, echo cycles per centimetre (58 us/cm at 50 MHz).
- TIMEOUT_CYCLES, 1900000, maximum cycles from trigger fall to echo fall (38 ms).
- GAP_CYCLES, 3000000, idle cycles between pings (60 ms ring-down).
- DIST_W, 18, distance result width.
- NEAR_CM, 20, proximity threshold in cm.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  in  1  run enable; level sensitive.
- mask  in  N_SENSORS  per-sensor enable; sampled in SELECT only.
- echo  in  N_SENSORS  raw echo pins; asynchronous.
- trig  out  N_SENSORS  trigger pins; at most one bit high.
- busy  out  1  high in every state except IDLE.
- dist_valid  out  1  one-cycle result strobe.
- dist_id  out  clog2(N_SENSORS)  sensor index of the current result.
- dist_cm  out  DIST_W  measured distance; all ones on timeout.
- dist_timeout  out  1  qualifies dist_valid; high means no valid echo.
- near  out  N_SENSORS  per-sensor flag, last valid result < NEAR_CM.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; trig, dist_valid, dist_timeout, dist_cm, dist_id, near all 0; busy=0.
  - Round-robin pointer = N_SENSORS-1, so the first sensor served is 0.
  - Reset asserted mid-ping drops trig on the next edge. No result is emitted.
- Echo is passed through a 2-flop synchronizer per bit. Edge detection uses synced echo[id] against its one-cycle-delayed copy. Pin-to-detect latency is 2-3 cycles.
- IDLE: if en=1 and mask!=0, go to SELECT. Otherwise stay.
- SELECT (1 cycle):
  - id = first set mask bit strictly after the pointer, wrapping; the pointer itself is chosen last. Update pointer to id.
  - If mask==0 here, go to IDLE. Otherwise go to TRIG.
- TRIG: trig[id]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE. Clear the timeout counter on exit.
- WAIT_RISE: wait for a rising edge of synced echo[id].
  - Echo already high on entry is stale and is ignored; a fresh low-to-high edge is required.
  - Timeout counter increments every cycle.
- MEASURE: on entry, cm=0 and the sub-counter is 0.
  - Each cycle echo stays high, the sub-counter increments.
  - When the sub-counter reaches DIV_CYCLES-1, it wraps to 0 and cm increments.
  - cm saturates at 2^DIST_W-1.
  - A falling edge of echo goes to REPORT with a valid result. The timeout counter keeps running.
- Timeout: if the timeout counter reaches TIMEOUT_CYCLES in WAIT_RISE or MEASURE, go to REPORT with dist_timeout=1 and dist_cm=all ones. Timeout takes priority if it occurs in the same cycle as the echo edge.
- REPORT (1 cycle):
  - dist_valid=1; dist_id, dist_cm and dist_timeout are driven and held until the next REPORT.
  - If not timeout, near[id] = (cm < NEAR_CM). On timeout, near[id] is cleared.
  - Then go to GAP.
- GAP: wait GAP_CYCLES cycles with all trig low. Then go to SELECT if en=1, else IDLE.
- en deassert mid-ping: the ping completes through REPORT and GAP, then the block goes to IDLE. en is checked only in IDLE and at GAP exit.
- Echo on non-selected sensors is ignored entirely.
- Sensors disabled in mask keep their last near value.

Test Plan (bench params TRIG_CYCLES=4, DIV_CYCLES=10, TIMEOUT_CYCLES=200, GAP_CYCLES=20, NEAR_CM=3, N_SENSORS=4):
- Reset then en=1, mask=4'b1111, model echo[0] high for 35 cycles, 5 cycles after trig falls -> trig[0] is high exactly 4 cycles; dist_valid with dist_id=0, dist_cm=3, dist_timeout=0, near[0]=0.
- Round-robin: mask=4'b1010, echoes answered -> dist_id sequence is 1, 3, 1, 3. Consecutive trig rises are separated by at least the full ping plus 20 gap cycles.
- No echo on sensor 2 -> dist_valid 200 cycles after trig falls, with dist_timeout=1, dist_cm=18'h3FFFF, near[2]=0. Also: echo stuck high for 250 cycles -> same timeout response.
- Stale echo: echo[0] already high at trig fall, then low 10 cycles, then high 25 cycles -> dist_cm=2 (fresh pulse measured), near[0]=1.
- Deassert en during MEASURE -> the result is still reported and GAP completes, then busy=0 and no further trig. Assert rst_n=0 during TRIG -> trig=0 on the next edge and no dist_valid follows.
- mask changed to 0 during GAP -> block returns to IDLE via SELECT with no further trig; dist_cm still holds the last result.
